// File: rtl/hc165_pkg.sv
// Shared types and sizing helpers for the 74HC165 chain scan controller.
package hc165_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        DONE     = 3'd4
    } state_e;

    function automatic int unsigned W(input int unsigned n_chips);
        return 8 * n_chips;
    endfunction

endpackage

// File: rtl/hc165_scan_ctrl_if.sv
// Chain pins plus game-side request/result signals of the scan controller.
interface hc165_scan_ctrl_if #(
    parameter int unsigned W = 16
);
    logic         START;
    logic         AUTO;
    logic         SER;
    logic         PL_n;
    logic         SCK;
    logic         CE_n;
    logic [W-1:0] DATA;
    logic         VALID;
    logic         CHG;
    logic         BUSY;

    modport master (
        input  START, AUTO, SER,
        output PL_n, SCK, CE_n, DATA, VALID, CHG, BUSY
    );

    modport slave (
        output START, AUTO, SER,
        input  PL_n, SCK, CE_n, DATA, VALID, CHG, BUSY
    );
endinterface

// File: rtl/hc165_phase_timer.sv
// Loadable down-counter; tc_c flags the last cycle of the loaded phase.
module hc165_phase_timer #(
    parameter int unsigned TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] val,
    output logic          tc_c
);
    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= val;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign tc_c = (cnt == '0);
endmodule

// File: rtl/hc165_scan_ctrl.sv
// Scans a daisy-chain of 74HC165s and presents the assembled word with VALID/CHG strobes.
module hc165_scan_ctrl
    import hc165_pkg::*;
#(
    parameter int unsigned N_CHIPS   = 2,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned PL_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    hc165_scan_ctrl_if.master   bus
);
    localparam int unsigned DW   = W(N_CHIPS);
    localparam int unsigned CW   = $clog2(DW);
    localparam int unsigned TMAX = (CLK_DIV > PL_CYCLES) ? CLK_DIV : PL_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    state_e          state;
    state_e          state_nx;
    logic [CW-1:0]   bit_cnt;
    logic [DW-1:0]   shreg;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_tc_c;

    // Timer is loaded with (phase length - 1) on entry to each timed phase.
    hc165_phase_timer #(.TW(TW)) u_timer (
        .clk  (CLK),
        .rst  (RST),
        .load (tmr_load),
        .val  (tmr_val),
        .tc_c (tmr_tc_c)
    );

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (bus.START || bus.AUTO) begin
                    state_nx = LOAD;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PL_CYCLES - 1);
                end
            end
            LOAD, SHIFT_LO: begin
                if (tmr_tc_c) begin
                    state_nx = (state == LOAD) ? SHIFT_LO : SHIFT_HI;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(CLK_DIV - 1);
                end
            end
            SHIFT_HI: begin
                if (tmr_tc_c) begin
                    if (bit_cnt == CW'(DW - 1)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = SHIFT_LO;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(CLK_DIV - 1);
                    end
                end
            end
            DONE: begin
                if (bus.AUTO) begin
                    state_nx = LOAD;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PL_CYCLES - 1);
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            bus.PL_n  <= 1'b1;
            bus.SCK   <= 1'b0;
            bus.CE_n  <= 1'b1;
            bus.DATA  <= '0;
            bus.VALID <= 1'b0;
            bus.CHG   <= 1'b0;
            bus.BUSY  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if (state == SHIFT_HI && tmr_tc_c && bit_cnt != CW'(DW - 1)) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
            // First-sampled bit ends up in the MSB after DW samples.
            if (state == SHIFT_LO && tmr_tc_c) begin
                shreg <= {shreg[DW-2:0], bus.SER};
            end
            bus.PL_n  <= (state_nx != LOAD);
            bus.SCK   <= (state_nx == SHIFT_HI);
            bus.CE_n  <= !(state_nx == SHIFT_LO || state_nx == SHIFT_HI);
            bus.BUSY  <= (state_nx != IDLE);
            bus.VALID <= (state_nx == DONE);
            bus.CHG   <= (state_nx == DONE) && (shreg != bus.DATA);
            if (state_nx == DONE) begin
                bus.DATA <= shreg;
            end
        end
    end
endmodule

// File: tb/tb_hc165_scan_ctrl.sv
// Bench for hc165_scan_ctrl driving behavioural 74HC165 chains on a default and a minimal instance.
module tb_hc165_scan_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hc165_scan_ctrl_if #(.W(16)) ifa ();
    hc165_scan_ctrl_if #(.W(8))  ifb ();

    hc165_scan_ctrl #(.N_CHIPS(2), .CLK_DIV(4), .PL_CYCLES(2)) dut_a (
        .CLK(clk), .RST(rst), .bus(ifa.master)
    );
    hc165_scan_ctrl #(.N_CHIPS(1), .CLK_DIV(1), .PL_CYCLES(1)) dut_b (
        .CLK(clk), .RST(rst), .bus(ifb.master)
    );

    // Chain models: {chip0, chip1}; chip 0 Q7 drives SER, shift on SCK rise while enabled.
    logic [15:0] par_a, chain_a;
    logic [7:0]  par_b, chain_b;
    always @(posedge ifa.SCK or negedge ifa.PL_n)
        if (!ifa.PL_n) chain_a <= par_a;
        else if (!ifa.CE_n) chain_a <= {chain_a[14:0], 1'b0};
    always @(posedge ifb.SCK or negedge ifb.PL_n)
        if (!ifb.PL_n) chain_b <= par_b;
        else if (!ifb.CE_n) chain_b <= {chain_b[6:0], 1'b0};
    assign ifa.SER = chain_a[15];
    assign ifb.SER = chain_b[7];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 400 && ifa.BUSY; i++) tick();
    endtask

    // One START-triggered scan; lat is the cycle index of VALID with START sampled at cycle 0.
    task automatic scan_a(output int lat, output logic [15:0] d, output logic c);
        wait_idle_a();
        lat = 0; d = 'x; c = 1'bx;
        ifa.START = 1'b1;
        tick();
        ifa.START = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            if (ifa.VALID) begin
                lat = i; d = ifa.DATA; c = ifa.CHG;
                break;
            end
            tick();
        end
        tick();
    endtask

    typedef struct {
        logic [15:0] in;
        logic [15:0] exp_d;
        logic        exp_c;
    } vec_t;

    initial begin
        vec_t        tbl[6];
        logic [15:0] prev;
        logic [15:0] d;
        logic        c;
        int          lat;

        tbl[0] = '{16'hA53C, 16'hA53C, 1'b1};
        tbl[1] = '{16'hA53C, 16'hA53C, 1'b0};
        tbl[2] = '{16'h0000, 16'h0000, 1'b1};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b0};
        tbl[5] = '{16'h1234, 16'h1234, 1'b1};

        rst = 1'b1;
        ifa.START = 1'b0; ifa.AUTO = 1'b0;
        ifb.START = 1'b0; ifb.AUTO = 1'b0;
        par_a = 16'h0; par_b = 8'h0;
        repeat (3) tick();
        chk("rst_pl_n", 32'(ifa.PL_n), 1);
        chk("rst_sck", 32'(ifa.SCK), 0);
        chk("rst_ce_n", 32'(ifa.CE_n), 1);
        chk("rst_data", 32'(ifa.DATA), 0);
        chk("rst_valid", 32'(ifa.VALID), 0);
        chk("rst_chg", 32'(ifa.CHG), 0);
        chk("rst_busy", 32'(ifa.BUSY), 0);
        rst = 1'b0;
        tick();

        // Directed table of consecutive single-shot scans.
        for (int i = 0; i < 6; i++) begin
            par_a = tbl[i].in;
            scan_a(lat, d, c);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 131);
            chk($sformatf("tbl%0d_data", i), 32'(d), 32'(tbl[i].exp_d));
            chk($sformatf("tbl%0d_chg", i), 32'(c), 32'(tbl[i].exp_c));
        end
        prev = 16'h1234;

        // Random words against the model: DATA follows the loaded inputs, CHG flags a difference.
        for (int i = 0; i < 8; i++) begin
            logic [15:0] w;
            w = ($urandom_range(0, 3) == 0) ? prev : 16'($urandom);
            par_a = w;
            scan_a(lat, d, c);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 131);
            chk($sformatf("rnd%0d_data", i), 32'(d), 32'(w));
            chk($sformatf("rnd%0d_chg", i), 32'(c), 32'(w != prev));
            prev = w;
        end

        // START pulsed during SHIFT_HI must be dropped.
        begin
            int nv = 0, busy_low = 0;
            bit pulsed = 0, seen_v = 0;
            wait_idle_a();
            par_a = 16'h5A5A;
            ifa.START = 1'b1;
            tick();
            ifa.START = 1'b0;
            for (int i = 1; i <= 350; i++) begin
                if (ifa.START) ifa.START = 1'b0;
                if (ifa.VALID) begin nv++; seen_v = 1; d = ifa.DATA; end
                if (!seen_v && !ifa.BUSY) busy_low++;
                if (!pulsed && ifa.SCK) begin ifa.START = 1'b1; pulsed = 1; end
                tick();
            end
            chk("ign_nvalid", 32'(nv), 1);
            chk("ign_busy", 32'(busy_low), 0);
            chk("ign_data", 32'(d), 32'h5A5A);
            chk("ign_idle", 32'(ifa.BUSY), 0);
            prev = 16'h5A5A;
        end

        // Free-running scans with inputs changed mid-scan.
        begin
            int vcyc[3];
            int nv = 0, nchg = 0;
            par_a = 16'hA53C;
            scan_a(lat, d, c);
            chk("auto_pre_data", 32'(d), 32'hA53C);
            ifa.AUTO = 1'b1;
            tick();
            for (int i = 1; i <= 600; i++) begin
                if (i == 60) par_a = 16'hFF00;
                if (ifa.VALID) begin
                    if (nv < 3) vcyc[nv] = i;
                    nv++;
                    if (ifa.CHG) nchg++;
                    if (nv == 3) ifa.AUTO = 1'b0;
                end
                tick();
            end
            chk("auto_nvalid", 32'(nv), 3);
            chk("auto_first", 32'(vcyc[0]), 131);
            chk("auto_per1", 32'(vcyc[1] - vcyc[0]), 131);
            chk("auto_per2", 32'(vcyc[2] - vcyc[1]), 131);
            chk("auto_nchg", 32'(nchg), 1);
            chk("auto_data", 32'(ifa.DATA), 32'hFF00);
            chk("auto_idle", 32'(ifa.BUSY), 0);
            prev = 16'hFF00;
        end

        // Reset while sampling bit 7 aborts the scan.
        begin
            int rises = 0, nv = 0;
            logic ps = 1'b0;
            wait_idle_a();
            par_a = 16'h0F0F;
            ifa.START = 1'b1;
            tick();
            ifa.START = 1'b0;
            for (int i = 1; i <= 200; i++) begin
                if (ifa.SCK && !ps) rises++;
                ps = ifa.SCK;
                if (rises == 7 && !ifa.SCK) break;
                tick();
            end
            chk("rstm_rises", 32'(rises), 7);
            rst = 1'b1;
            tick();
            chk("rstm_pl_n", 32'(ifa.PL_n), 1);
            chk("rstm_sck", 32'(ifa.SCK), 0);
            chk("rstm_ce_n", 32'(ifa.CE_n), 1);
            chk("rstm_data", 32'(ifa.DATA), 0);
            chk("rstm_valid", 32'(ifa.VALID), 0);
            chk("rstm_busy", 32'(ifa.BUSY), 0);
            rst = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (ifa.VALID) nv++;
                tick();
            end
            chk("rstm_novalid", 32'(nv), 0);
            scan_a(lat, d, c);
            chk("rstm_lat", 32'(lat), 131);
            chk("rstm_after_data", 32'(d), 32'h0F0F);
            chk("rstm_after_chg", 32'(c), 1);
        end

        // Minimal configuration: one chip, single-cycle phases.
        begin
            int rises = 0, pl_low = 0, vlat = 0;
            logic ps = 1'b0;
            logic [7:0] bd = 'x;
            logic bc = 1'bx;
            par_b = 8'h81;
            ifb.START = 1'b1;
            tick();
            ifb.START = 1'b0;
            for (int i = 1; i <= 60; i++) begin
                if (ifb.SCK && !ps) rises++;
                ps = ifb.SCK;
                if (!ifb.PL_n) pl_low++;
                if (ifb.VALID && vlat == 0) begin vlat = i; bd = ifb.DATA; bc = ifb.CHG; end
                tick();
            end
            chk("b_lat", 32'(vlat), 18);
            chk("b_data", 32'(bd), 32'h81);
            chk("b_chg", 32'(bc), 1);
            chk("b_rises", 32'(rises), 8);
            chk("b_pl_low", 32'(pl_low), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
